ram_bram_responder: RTL
=======================

// Module: ram_bram_responder
// PURPOSE
//  Responder end of the processor ram_* handshake (addr/wr_data/rd_data/wr_en/rd_en/busy/rd_ready/rd_ack).
//  Serves processor_port requests from on-chip block RAM in place of the SDRAM path.
//  Used for boot/scratch memory and for simulation without an SDRAM model.
//  Programmable wait states so the processor sees SDRAM-like timing.
// PARAMETERS
//  ADDR_W  10  word-address bits actually decoded; depth = 2**ADDR_W x 16-bit
//  RD_LAT  2   edges from read acceptance to rd_ready; legal range 1..15
//  WR_LAT  1   edges busy stays high after write acceptance; legal range 1..15
// PORTS
//  clk           in   1   single clock (mclk domain)
//  rst           in   1   asynchronous, active-high reset
//  ram_addr      in   24  word address; bits [ADDR_W-1:0] decoded
//  ram_wr_data   in   16  write data
//  ram_rd_data   out  16  read data; valid while ram_rd_ready=1
//  ram_wr_en     in   1   write request
//  ram_rd_en     in   1   read request
//  ram_busy      out  1   1 = request in progress, new requests ignored
//  ram_rd_ready  out  1   read data valid; held until ram_rd_ack
//  ram_rd_ack    in   1   initiator consumed read data
//  ram_err       out  1   only with RAM_ERR_EN: out-of-range access flag
// BEHAVIOUR
//  Reset: ram_busy=0, ram_rd_ready=0, ram_rd_data=0, ram_err=0, FSM=IDLE; array contents untouched.
//  Reset mid-operation aborts the operation. A write accepted before reset has already been committed.
//  FSM states: IDLE, WR_WAIT, RD_WAIT, RD_VALID.
//  IDLE:
//   - Request accepted on edge E0 only when ram_busy=0. Address/data are registered at E0.
//   - wr_en=1: array written at E0; busy=1 from E0; -> WR_WAIT.
//   - rd_en=1 (wr_en=0): busy=1 from E0; -> RD_WAIT.
//   - wr_en=1 and rd_en=1: write wins; the read is dropped, not queued.
//  WR_WAIT: counter runs WR_LAT edges; busy=0 after edge E0+WR_LAT; -> IDLE.
//  RD_WAIT: counter runs RD_LAT edges; at E0+RD_LAT rd_data loads and rd_ready=1; -> RD_VALID.
//  RD_VALID:
//   - rd_data and rd_ready are held stable; busy stays 1.
//   - On the first edge sampling ack=1: rd_ready=0, busy=0; -> IDLE. rd_data keeps its last value.
//  rd_ack sampled while rd_ready=0 is ignored.
//  Requests while busy=1 are ignored and never latched.
//  Without RAM_ERR_EN:
//   - Address bits above ADDR_W-1 are ignored, so addresses alias modulo 2**ADDR_W.
//   - Back-to-back requests: the next request is accepted on the edge after busy falls.
//  Minimum read turnaround is RD_LAT+1 edges when ack is tied high.
// CONFIGURATION
//  Macro RAM_ERR_EN.
//  Defined:
//   - Any accepted access with ram_addr[23:ADDR_W]!=0 sets ram_err=1, held until the next accepted request.
//   - An out-of-range write does not modify the array.
//   - An out-of-range read returns 16'hDEAD and completes normally.
//  Undefined: ram_err is tied 0 and aliasing applies.
// STRUCTURE
//  Package ram_bus_pkg:
//   - ram_state_e enum {IDLE, WR_WAIT, RD_WAIT, RD_VALID}.
//   - RAM_ADDR_W=24, RAM_DATA_W=16, RAM_ERR_WORD=16'hDEAD.
//  Sub-module ram_bram_array: single-port synchronous RAM, 1-cycle read, write-first, no reset.
//  Top of block: FSM, 4-bit latency counter, address/data capture registers, rd_data hold register.
// TESTING
//  1. Write 0x1234 @0x000010, then read @0x000010 with ack tied 1 -> rd_ready 2 edges after acceptance, rd_data=0x1234, busy low next edge.
//  2. Read with ack delayed 5 cycles -> rd_ready and rd_data stable all 5 cycles; busy=1 throughout; both drop after the ack edge.
//  3. Write 0xBEEF @0x20 while busy from a prior read -> no write; later read @0x20 returns the old value.
//  4. wr_en and rd_en both high, addr 0x30, data 0x5555 -> write performed; rd_ready never asserts; readback=0x5555.
//  5. Assert rst during RD_WAIT -> busy/rd_ready/rd_data=0 immediately; post-reset read of a previously written word returns its data.
//  6. ADDR_W=10: write 0xA5A5 @0x000400.
//     - Without RAM_ERR_EN: read @0x000000 = 0xA5A5.
//     - With RAM_ERR_EN: ram_err=1, @0x000000 unchanged, read @0x000400 = 0xDEAD.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the processor ram_* handshake.
package ram_bus_pkg;
    localparam int RAM_ADDR_W = 24;
    localparam int RAM_DATA_W = 16;
    localparam logic [RAM_DATA_W-1:0] RAM_ERR_WORD = 16'hDEAD;

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RD_VALID} ram_state_e;
endpackage

// File: rtl/ram_bram_responder_if.sv
// Processor ram_* handshake bundle; master = initiator, slave = responder.
interface ram_bram_responder_if;
    import ram_bus_pkg::*;

    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [RAM_DATA_W-1:0] ram_wr_data;
    logic [RAM_DATA_W-1:0] ram_rd_data;
    logic                  ram_wr_en;
    logic                  ram_rd_en;
    logic                  ram_busy;
    logic                  ram_rd_ready;
    logic                  ram_rd_ack;
    logic                  ram_err;

    modport master (
        output ram_addr, ram_wr_data, ram_wr_en, ram_rd_en, ram_rd_ack,
        input  ram_rd_data, ram_busy, ram_rd_ready, ram_err
    );

    modport slave (
        input  ram_addr, ram_wr_data, ram_wr_en, ram_rd_en, ram_rd_ack,
        output ram_rd_data, ram_busy, ram_rd_ready, ram_err
    );
endinterface

// File: rtl/ram_bram_array.sv
// Single-port synchronous block RAM: 1-cycle read, write-first, contents never reset.
module ram_bram_array #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            o_rdata       <= i_wdata;
        end else begin
            o_rdata       <= r_mem[i_addr];
        end
    end
endmodule

// File: rtl/ram_bram_responder.sv
// Block-RAM responder for the processor ram_* handshake with programmable wait states.
// Define RAM_ERR_EN to flag and suppress accesses with address bits above ADDR_W-1.
module ram_bram_responder #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_bram_responder_if.slave  bus
);
    import ram_bus_pkg::*;

    localparam logic [3:0] RD_CNT = 4'(RD_LAT);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT);

    ram_state_e              r_state;
    logic [3:0]              r_cnt;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_oor;
    logic                    r_busy;
    logic                    r_rd_ready;
    logic [RAM_DATA_W-1:0]   r_rd_data;
    logic                    r_err;

    logic                    w_oor;
    logic                    w_we;
    logic [ADDR_W-1:0]       w_arr_addr;
    logic [RAM_DATA_W-1:0]   w_arr_rdata;

`ifdef RAM_ERR_EN
    assign w_oor = |bus.ram_addr[RAM_ADDR_W-1:ADDR_W];
`else
    // High address bits are decoded away entirely: plain aliasing.
    assign w_oor = 1'b0;
    logic w_unused_hi;
    assign w_unused_hi = ^bus.ram_addr[RAM_ADDR_W-1:ADDR_W];
`endif

    // The array commits on the acceptance edge itself, so it sees the live bus in IDLE.
    assign w_we       = (r_state == IDLE) && bus.ram_wr_en && !w_oor;
    assign w_arr_addr = (r_state == IDLE) ? bus.ram_addr[ADDR_W-1:0] : r_addr;

    ram_bram_array #(
        .AW (ADDR_W),
        .DW (RAM_DATA_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_arr_addr),
        .i_wdata (bus.ram_wr_data),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_oor      <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_ready <= 1'b0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ram_wr_en || bus.ram_rd_en) begin
                        r_busy  <= 1'b1;
                        r_cnt   <= 4'd1;
                        r_addr  <= bus.ram_addr[ADDR_W-1:0];
                        r_oor   <= w_oor;
                        r_err   <= w_oor;
                        // Write wins over a simultaneous read; the read is dropped.
                        r_state <= bus.ram_wr_en ? WR_WAIT : RD_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (r_cnt == WR_CNT) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                RD_WAIT: begin
                    if (r_cnt == RD_CNT) begin
                        r_rd_data  <= r_oor ? RAM_ERR_WORD : w_arr_rdata;
                        r_rd_ready <= 1'b1;
                        r_state    <= RD_VALID;
                    end else begin
                        r_cnt      <= r_cnt + 4'd1;
                    end
                end
                RD_VALID: begin
                    if (bus.ram_rd_ack) begin
                        r_rd_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ram_busy     = r_busy;
    assign bus.ram_rd_ready = r_rd_ready;
    assign bus.ram_rd_data  = r_rd_data;
    assign bus.ram_err      = r_err;
endmodule
